// File: rtl/stash_scan_reader.sv
// rtl/stash_scan_reader.sv - write-back scan of the stash scan table into a 2-entry output FIFO
// Each entry takes two scan-table cycles: a read, then a clear back to SNULL.
module stash_scan_reader #(
  parameter int ORAMZ           = 4,
  parameter int ORAML           = 10,
  parameter int StashEAWidth    = 7,
  parameter int ScanTableAWidth = 6
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       ScanTableResetDone,
  output logic [ScanTableAWidth-1:0] STAddr,
  output logic                       STValid,
  output logic                       STReset,
  input  logic [StashEAWidth-1:0]    STData,
  input  logic                       STDataValid,
  output logic [StashEAWidth-1:0]    OutSAddr,
  output logic                       OutDummy,
  output logic                       OutLast,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic                       Busy,
  output logic                       Done
);

  localparam int BlocksOnPath = ORAMZ * (ORAML + 1);
  localparam logic [StashEAWidth-1:0]    SNULL     = '1;
  localparam logic [ScanTableAWidth-1:0] last_addr = ScanTableAWidth'(BlocksOnPath - 1);

  typedef enum logic [1:0] {IDLE, READ, CLEAR, DRAIN} state_t;

  state_t                     state;
  logic [ScanTableAWidth-1:0] addr;
  logic                       read_pending;
  logic [StashEAWidth:0]      fifo_mem [2];
  logic                       wr_ptr;
  logic                       rd_ptr;
  logic [1:0]                 fifo_count;

  logic issue_read;
  logic is_last;
  logic push;
  logic pop;
  logic [StashEAWidth:0] head;

  // A read is only issued while a FIFO slot is guaranteed for its response.
  assign issue_read = (state == READ) && (fifo_count < 2'd2);
  assign is_last    = (addr == last_addr);
  assign push       = read_pending && STDataValid;
  assign pop        = OutValid && OutReady;
  assign head       = fifo_mem[rd_ptr];

  assign STAddr   = addr;
  assign STValid  = issue_read || (state == CLEAR);
  assign STReset  = (state == CLEAR);
  assign OutValid = (fifo_count != 2'd0);
  assign OutSAddr = OutValid ? head[StashEAWidth:1] : '0;
  assign OutLast  = OutValid && head[0];
  assign OutDummy = OutValid && (head[StashEAWidth:1] == SNULL);
  assign Busy     = (state != IDLE);
  assign Done     = (state == DRAIN) && (fifo_count == 2'd0) && !read_pending;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      addr         <= '0;
      read_pending <= 1'b0;
    end else begin
      if (issue_read)
        read_pending <= 1'b1;
      else if (STDataValid)
        read_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (Start && ScanTableResetDone) begin
            addr  <= '0;
            state <= READ;
          end
        end
        READ: begin
          if (issue_read)
            state <= CLEAR;
        end
        CLEAR: begin
          if (is_last) begin
            state <= DRAIN;
          end else begin
            addr  <= addr + 1'b1;
            state <= READ;
          end
        end
        DRAIN: begin
          if (Done)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Push tags the entry with the current addr: the response lands during CLEAR,
  // before addr advances.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {STData, is_last};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule
